// File: rtl/keypad_matrix_scanner.sv
// ============================================================================
// Module   : keypad_matrix_scanner
// Purpose  : Debounced ROWS x COLS keypad scanner with press/release pulses.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module keypad_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DIV      = 100,
    parameter int DEBOUNCE = 4,
    parameter int RW       = $clog2(ROWS + 1),
    parameter int CW       = $clog2(COLS + 1),
    parameter int KW       = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row_b,
    output logic [COLS-1:0] col,
    output logic [RW-1:0]   row_idx,
    output logic [CW-1:0]   col_idx,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_release,
    output logic            key_held,
    output logic            multi
);

    localparam int TW  = $clog2(DIV);
    localparam int CIW = $clog2(COLS);
    localparam int DW  = $clog2(DEBOUNCE + 1);

    localparam logic [COLS-1:0] ONE_HOT0 = COLS'(1);
    localparam logic [RW-1:0]   ROW_NONE = RW'(ROWS);
    localparam logic [CW-1:0]   COL_NONE = CW'(COLS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DEB  = 2'd2,
        S_HELD = 2'd3
    } state_t;

    state_t          state_q;
    logic [ROWS-1:0] rs_meta_q;
    logic [ROWS-1:0] rs_q;
    logic [TW-1:0]   tcnt_q;
    logic [TW-1:0]   tcnt_d;
    logic            tick;
    logic [CIW-1:0]  c_q;
    logic [ROWS-1:0] pat_q;
    logic [DW-1:0]   dcnt_q;
    logic [DW-1:0]   rc_q;
    logic [COLS-1:0] col_q;
    logic [RW-1:0]   row_idx_q;
    logic [CW-1:0]   col_idx_q;
    logic [KW-1:0]   key_code_q;
    logic            key_valid_q;
    logic            key_release_q;
    logic            key_held_q;
    logic            multi_q;

    logic [RW-1:0]   hit_row;
    logic [KW-1:0]   hit_code;
    logic            hit_multi;

    function automatic logic [COLS-1:0] f_strobe(input logic [CIW-1:0] idx);
        f_strobe = ~(ONE_HOT0 << idx);
    endfunction

    function automatic logic [RW-1:0] f_low_row(input logic [ROWS-1:0] p);
        f_low_row = ROW_NONE;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!p[i]) f_low_row = RW'(i);
        end
    endfunction

    function automatic logic f_many(input logic [ROWS-1:0] p);
        int n;
        n = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (!p[i]) n++;
        end
        f_many = (n > 1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta_q <= '1;
            rs_q      <= '1;
        end else begin
            rs_meta_q <= row_b;
            rs_q      <= rs_meta_q;
        end
    end

    assign tick   = (tcnt_q == TW'(DIV - 1));
    assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt_q <= '0;
        else        tcnt_q <= tcnt_d;
    end

    always_comb begin
        hit_row   = f_low_row(pat_q);
        hit_multi = f_many(pat_q);
        hit_code  = KW'(int'(hit_row) * COLS + int'(c_q));
    end

    // The strobed column stays driven from SCAN through HELD so the same key
    // keeps being sensed until it is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            c_q           <= '0;
            pat_q         <= '1;
            dcnt_q        <= '0;
            rc_q          <= '0;
            col_q         <= '0;
            row_idx_q     <= ROW_NONE;
            col_idx_q     <= COL_NONE;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_held_q    <= 1'b0;
            multi_q       <= 1'b0;
        end else begin
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rs_q != '1) begin
                            c_q     <= '0;
                            col_q   <= f_strobe('0);
                            state_q <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (rs_q != '1) begin
                            pat_q   <= rs_q;
                            dcnt_q  <= DW'(1);
                            state_q <= S_DEB;
                        end else if (c_q == CIW'(COLS - 1)) begin
                            col_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            c_q   <= c_q + 1'b1;
                            col_q <= f_strobe(c_q + 1'b1);
                        end
                    end
                    S_DEB: begin
                        if (rs_q == pat_q) begin
                            if (dcnt_q == DW'(DEBOUNCE)) begin
                                state_q     <= S_HELD;
                                rc_q        <= '0;
                                row_idx_q   <= hit_row;
                                col_idx_q   <= CW'(c_q);
                                key_code_q  <= hit_code;
                                multi_q     <= hit_multi;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                dcnt_q <= dcnt_q + 1'b1;
                            end
                        end else begin
                            col_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        if (rs_q == '1) begin
                            if (rc_q == DW'(DEBOUNCE - 1)) begin
                                state_q       <= S_IDLE;
                                col_q         <= '0;
                                key_release_q <= 1'b1;
                                key_held_q    <= 1'b0;
                                row_idx_q     <= ROW_NONE;
                                col_idx_q     <= COL_NONE;
                                multi_q       <= 1'b0;
                            end else begin
                                rc_q <= rc_q + 1'b1;
                            end
                        end else begin
                            rc_q <= '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign col         = col_q;
    assign row_idx     = row_idx_q;
    assign col_idx     = col_idx_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_held    = key_held_q;
    assign multi       = multi_q;

endmodule

`default_nettype wire
